// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters, blanking, sync, line/frame strobes and vblank irq.
// Optional interlace fields are enabled by defining VIDEO_TIMING_INTERLACE_EN.
module video_timing_gen #(
   parameter int unsigned HW        = 9,
   parameter int unsigned VW        = 9,
   parameter int unsigned H_TOTAL   = 387,
   parameter int unsigned H_OFS     = 32,
   parameter int unsigned HBL_START = 352,
   parameter int unsigned HBL_END   = 32,
   parameter int unsigned HS_START  = 364,
   parameter int unsigned HS_END    = 380,
   parameter int unsigned V_TOTAL   = 262,
   parameter int unsigned V_OFS     = 0,
   parameter int unsigned VBL_START = 248,
   parameter int unsigned VBL_END   = 8,
   parameter int unsigned VS_START  = 252,
   parameter int unsigned VS_END    = 256,
   parameter int unsigned MAX_OFS   = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ce_pix,
   input  logic [HW-1:0] hs_offset,
   input  logic [VW-1:0] vs_offset,
   output logic [HW-1:0] hc,
   output logic [VW-1:0] vc,
   output logic          hbl,
   output logic          vbl,
   output logic          hsync,
   output logic          vsync,
   output logic          line_start,
   output logic          frame_start,
   output logic          vbl_irq,
   output logic          field
);

   localparam int unsigned HXW = HW + 2;
   localparam int unsigned VXW = VW + 2;

   localparam logic signed [HXW-1:0] H_TOT_S = HXW'(H_TOTAL);
   localparam logic signed [HXW-1:0] H_MAX_S = HXW'(MAX_OFS);
   localparam logic signed [HXW-1:0] HS0_S   = HXW'(HS_START);
   localparam logic signed [HXW-1:0] HS1_S   = HXW'(HS_END);
   localparam logic signed [VXW-1:0] V_TOT_S = VXW'(V_TOTAL);
   localparam logic signed [VXW-1:0] V_MAX_S = VXW'(MAX_OFS);
   localparam logic signed [VXW-1:0] VS0_S   = VXW'(VS_START);
   localparam logic signed [VXW-1:0] VS1_S   = VXW'(VS_END);

   logic [HW-1:0]         r_h;
   logic [HW-1:0]         w_h_nxt;
   logic [VW-1:0]         r_v;
   logic [VW-1:0]         w_v_nxt;
   logic signed [HXW-1:0] r_hofs;
   logic signed [HXW-1:0] w_hofs_ext;
   logic signed [HXW-1:0] w_hofs_sat;
   logic signed [HXW-1:0] w_hofs_use;
   logic signed [VXW-1:0] r_vofs;
   logic signed [VXW-1:0] w_vofs_ext;
   logic signed [VXW-1:0] w_vofs_sat;
   logic signed [VXW-1:0] w_vofs_use;
   logic                  w_field_use;
   logic                  w_h_last;
   logic                  w_v_last;
   logic                  w_line_nxt;
   logic                  w_frame_nxt;
   logic                  w_irq_nxt;
   logic [HW-1:0]         w_hs0;
   logic [HW-1:0]         w_hs1;
   logic [VW-1:0]         w_vs0;
   logic [VW-1:0]         w_vs1;
   logic                  w_hs_nxt;
   logic                  w_vs_nxt;
`ifdef VIDEO_TIMING_INTERLACE_EN
   logic [VW-1:0]         w_v_prev;
`endif

   // Half-open window [s0,s1) that may wrap past the end of the line/frame; empty when s0==s1.
   function automatic logic in_window(input int unsigned p, input int unsigned s0,
                                      input int unsigned s1);
      if (s0 < s1)      return (p >= s0) && (p < s1);
      else if (s0 > s1) return (p >= s0) || (p < s1);
      else              return 1'b0;
   endfunction

   // A shifted edge is at most MAX_OFS outside the range, so one correction suffices.
   function automatic logic [HW-1:0] wrap_h(input logic signed [HXW-1:0] x);
      logic signed [HXW-1:0] y;
      if (x[HXW-1])         y = x + H_TOT_S;
      else if (x >= H_TOT_S) y = x - H_TOT_S;
      else                  y = x;
      return HW'(y);
   endfunction

   function automatic logic [VW-1:0] wrap_v(input logic signed [VXW-1:0] x);
      logic signed [VXW-1:0] y;
      if (x[VXW-1])         y = x + V_TOT_S;
      else if (x >= V_TOT_S) y = x - V_TOT_S;
      else                  y = x;
      return VW'(y);
   endfunction

   // Next raw position; reset is folded in so outputs decode h=0,v=0 on the reset edge.
   always_comb begin
      w_h_last = (r_h == HW'(H_TOTAL - 1));
`ifdef VIDEO_TIMING_INTERLACE_EN
      w_v_last = (r_v == (field ? VW'(V_TOTAL) : VW'(V_TOTAL - 1)));
`else
      w_v_last = (r_v == VW'(V_TOTAL - 1));
`endif
      w_line_nxt  = ce_pix & w_h_last & ~reset;
      w_frame_nxt = w_line_nxt & w_v_last;
      w_h_nxt     = r_h;
      w_v_nxt     = r_v;
      if (reset) begin
         w_h_nxt = '0;
         w_v_nxt = '0;
      end else if (ce_pix) begin
         w_h_nxt = w_h_last ? '0 : r_h + 1'b1;
         if (w_h_last) w_v_nxt = w_v_last ? '0 : r_v + 1'b1;
      end
      w_irq_nxt = w_line_nxt & (w_v_nxt == VW'(VBL_START));
   end

   // Offsets saturate continuously but only take effect on the frame_start edge.
   always_comb begin
      w_hofs_ext = HXW'($signed(hs_offset));
      w_vofs_ext = VXW'($signed(vs_offset));
      if (w_hofs_ext > H_MAX_S)       w_hofs_sat = H_MAX_S;
      else if (w_hofs_ext < -H_MAX_S) w_hofs_sat = -H_MAX_S;
      else                            w_hofs_sat = w_hofs_ext;
      if (w_vofs_ext > V_MAX_S)       w_vofs_sat = V_MAX_S;
      else if (w_vofs_ext < -V_MAX_S) w_vofs_sat = -V_MAX_S;
      else                            w_vofs_sat = w_vofs_ext;
      w_hofs_use = r_hofs;
      w_vofs_use = r_vofs;
      if (reset) begin
         w_hofs_use = '0;
         w_vofs_use = '0;
      end else if (w_frame_nxt) begin
         w_hofs_use = w_hofs_sat;
         w_vofs_use = w_vofs_sat;
      end
`ifdef VIDEO_TIMING_INTERLACE_EN
      w_field_use = reset ? 1'b0 : (w_frame_nxt ? ~field : field);
`else
      w_field_use = 1'b0;
`endif
   end

   // Sync decode from the next position and the offsets in force for it.
   always_comb begin
      w_hs0    = wrap_h(HS0_S + w_hofs_use);
      w_hs1    = wrap_h(HS1_S + w_hofs_use);
      w_vs0    = wrap_v(VS0_S + w_vofs_use);
      w_vs1    = wrap_v(VS1_S + w_vofs_use);
      w_hs_nxt = in_window(32'(w_h_nxt), 32'(w_hs0), 32'(w_hs1));
`ifdef VIDEO_TIMING_INTERLACE_EN
      // Odd field: vsync edges move to mid-line, i.e. the first half of a line uses the previous line.
      w_v_prev = (w_v_nxt == '0) ? VW'(V_TOTAL - 1) : w_v_nxt - 1'b1;
      if (w_field_use && (w_h_nxt < HW'(H_TOTAL / 2)))
         w_vs_nxt = in_window(32'(w_v_prev), 32'(w_vs0), 32'(w_vs1));
      else
         w_vs_nxt = in_window(32'(w_v_nxt), 32'(w_vs0), 32'(w_vs1));
`else
      w_vs_nxt = in_window(32'(w_v_nxt), 32'(w_vs0), 32'(w_vs1));
`endif
   end

   always_ff @(posedge clk) begin
      r_h         <= w_h_nxt;
      r_v         <= w_v_nxt;
      r_hofs      <= w_hofs_use;
      r_vofs      <= w_vofs_use;
      hc          <= w_h_nxt - HW'(H_OFS);
      vc          <= w_v_nxt - VW'(V_OFS);
      hbl         <= (w_h_nxt >= HW'(HBL_START)) | (w_h_nxt < HW'(HBL_END));
      vbl         <= (w_v_nxt >= VW'(VBL_START)) | (w_v_nxt < VW'(VBL_END));
      hsync       <= w_hs_nxt;
      vsync       <= w_vs_nxt;
      line_start  <= w_line_nxt;
      frame_start <= w_frame_nxt;
      vbl_irq     <= w_irq_nxt;
      field       <= w_field_use;
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen (progressive build) using a reduced 40x20 raster
// so whole frames stay short; expected masks below are hand-derived for these parameters.
module tb_video_timing_gen;

   localparam int unsigned HW = 9;
   localparam int unsigned VW = 9;
   localparam int unsigned HT = 40;
   localparam int unsigned VT = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          ce_pix;
   logic [HW-1:0] hs_offset;
   logic [VW-1:0] vs_offset;
   logic [HW-1:0] hc;
   logic [VW-1:0] vc;
   logic          hbl, vbl, hsync, vsync, line_start, frame_start, vbl_irq, field;

   int n_chk  = 0;
   int n_pass = 0;
   int tb_h   = 0;
   int tb_v   = 0;

   logic [HT-1:0] m_hs, m_hbl;
   logic [VT-1:0] m_vs, m_vbl;
   logic [HW-1:0] hc_at;
   logic [VW-1:0] vc_at;
   logic [HW-1:0] chg_hofs;
   int c_ls, c_fs, c_irq, irq_pos, fs_tick, probe_line, chg_v;

   always #5 clk = ~clk;

   video_timing_gen #(
      .HW(HW), .VW(VW), .H_TOTAL(HT), .H_OFS(4), .HBL_START(32), .HBL_END(4),
      .HS_START(34), .HS_END(38), .V_TOTAL(VT), .V_OFS(2), .VBL_START(16),
      .VBL_END(2), .VS_START(17), .VS_END(19), .MAX_OFS(8)
   ) dut (
      .clk(clk), .reset(reset), .ce_pix(ce_pix), .hs_offset(hs_offset),
      .vs_offset(vs_offset), .hc(hc), .vc(vc), .hbl(hbl), .vbl(vbl),
      .hsync(hsync), .vsync(vsync), .line_start(line_start),
      .frame_start(frame_start), .vbl_irq(vbl_irq), .field(field)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One clock; the bench tracks the raw position independently of the DUT.
   task automatic tick(input logic ce);
      ce_pix = ce;
      @(posedge clk);
      #1;
      if (reset) begin
         tb_h = 0;
         tb_v = 0;
      end else if (ce) begin
         if (tb_h == int'(HT - 1)) begin
            tb_h = 0;
            tb_v = (tb_v == int'(VT - 1)) ? 0 : tb_v + 1;
         end else begin
            tb_h++;
         end
      end
   endtask

   // Runs one full frame from (0,0) to the next (0,0), collecting masks and strobe counts.
   task automatic scan_frame();
      m_hs = '0; m_hbl = '0; m_vs = '0; m_vbl = '0;
      c_ls = 0; c_fs = 0; c_irq = 0; irq_pos = -1; fs_tick = -1;
      for (int i = 1; i <= int'(HT * VT); i++) begin
         if (tb_v == chg_v && tb_h == 0) hs_offset = chg_hofs;
         tick(1'b1);
         if (tb_v == probe_line) begin
            m_hs  = m_hs  | (HT'(hsync) << tb_h);
            m_hbl = m_hbl | (HT'(hbl)   << tb_h);
         end
         if (tb_h == 0) begin
            m_vs  = m_vs  | (VT'(vsync) << tb_v);
            m_vbl = m_vbl | (VT'(vbl)   << tb_v);
         end
         if (tb_h == 10 && tb_v == 7) begin
            hc_at = hc;
            vc_at = vc;
         end
         c_ls  += int'(line_start);
         c_fs  += int'(frame_start);
         c_irq += int'(vbl_irq);
         if (vbl_irq)     irq_pos = tb_v * int'(HT) + tb_h;
         if (frame_start) fs_tick = i;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [21:0] snap;
      int hold_err, ls_cyc, fs_cyc;
      reset = 1'b1; ce_pix = 1'b0; hs_offset = '0; vs_offset = '0;
      chg_v = -1; chg_hofs = '0; probe_line = 5;
      tick(1'b0);
      tick(1'b1);
      reset = 1'b0;

      check("rst_hc", 64'(hc), 64'd508);
      check("rst_vc", 64'(vc), 64'd510);
      check("rst_blank", 64'({hbl, vbl}), 64'b11);
      check("rst_sync", 64'({hsync, vsync}), 64'b00);
      check("rst_strobes", 64'({line_start, frame_start, vbl_irq}), 64'b000);

      // Frame 0: offsets latched at reset are zero; new hs_offset must not act mid-frame.
      hs_offset = HW'(5);
      scan_frame();
      check("f0_hbl_mask", 64'(m_hbl), 64'hFF_0000_000F);
      check("f0_hs_mask", 64'(m_hs), 64'h3C_0000_0000);
      check("f0_vs_mask", 64'(m_vs), 64'h6_0000);
      check("f0_vbl_mask", 64'(m_vbl), 64'hF_0003);
      check("f0_line_starts", 64'(c_ls), 64'd20);
      check("f0_frame_starts", 64'(c_fs), 64'd1);
      check("f0_irq_count", 64'(c_irq), 64'd1);
      check("f0_irq_pos", 64'(irq_pos), 64'd640);
      check("f0_frame_period", 64'(fs_tick), 64'd800);
      check("f0_hc_mid", 64'(hc_at), 64'd6);
      check("f0_vc_mid", 64'(vc_at), 64'd5);

      // Frame 1: hofs=+5 wraps hsync to h 39,0,1,2.
      hs_offset = HW'(-100);
      vs_offset = VW'(-100);
      scan_frame();
      check("f1_hs_wrap", 64'(m_hs), 64'h80_0000_0007);
      check("f1_vs_unlatched", 64'(m_vs), 64'h6_0000);
      check("f1_frame_period", 64'(fs_tick), 64'd800);

      // Frame 2: -100 saturates to -8 on both axes.
      hs_offset = '0;
      vs_offset = '0;
      scan_frame();
      check("f2_hs_sat_neg", 64'(m_hs), 64'h00_3C00_0000);
      check("f2_vs_sat_neg", 64'(m_vs), 64'h0_0600);

      // Frame 3: hs_offset changes to +3 at line 5; line 10 keeps the old edges.
      chg_v = 5; chg_hofs = HW'(3); probe_line = 10;
      scan_frame();
      check("f3_hs_midframe", 64'(m_hs), 64'h3C_0000_0000);
      check("f3_vs_back", 64'(m_vs), 64'h6_0000);

      // Frame 4: +3 now in force: h 37..39 and 0.
      chg_v = -1; probe_line = 3;
      hs_offset = HW'(100);
      scan_frame();
      check("f4_hs_latched", 64'(m_hs), 64'hE0_0000_0001);

      // Frame 5: +100 saturates to +8: h 2..5.
      scan_frame();
      check("f5_hs_sat_pos", 64'(m_hs), 64'h00_0000_003C);

      // ce_pix every 4th clk from (0,0): levels hold, one single-clk line_start.
      hold_err = 0; ls_cyc = 0; fs_cyc = 0;
      for (int p = 0; p < 45; p++) begin
         tick(1'b1);
         ls_cyc += int'(line_start);
         fs_cyc += int'(frame_start);
         snap = {hc, vc, hbl, vbl, hsync, vsync};
         for (int k = 0; k < 3; k++) begin
            tick(1'b0);
            if (snap != {hc, vc, hbl, vbl, hsync, vsync}) hold_err++;
            ls_cyc += int'(line_start);
            fs_cyc += int'(frame_start);
         end
      end
      check("ce4_hold", 64'(hold_err), 64'd0);
      check("ce4_ls_cycles", 64'(ls_cyc), 64'd1);
      check("ce4_fs_cycles", 64'(fs_cyc), 64'd0);
      check("ce4_hc", 64'(hc), 64'd1);
      check("ce4_vc", 64'(vc), 64'd511);

      // Mid-frame reset at (20,7) with ce_pix low restarts at (0,0) without frame_start.
      for (int i = 0; i < int'(HT * VT) && !(tb_v == 7 && tb_h == 20); i++) tick(1'b1);
      check("pre_rst_hc", 64'(hc), 64'd16);
      check("pre_rst_vc", 64'(vc), 64'd5);
      reset = 1'b1;
      tick(1'b0);
      reset = 1'b0;
      check("mrst_hc", 64'(hc), 64'd508);
      check("mrst_vc", 64'(vc), 64'd510);
      check("mrst_blank", 64'({hbl, vbl}), 64'b11);
      check("mrst_strobes", 64'({line_start, frame_start, vbl_irq}), 64'b000);
      tick(1'b1);
      check("post_rst_hc", 64'(hc), 64'd509);
      check("post_rst_fs", 64'(frame_start), 64'd0);
`ifndef VIDEO_TIMING_INTERLACE_EN
      check("field_tied", 64'(field), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
